// File: rtl/vec_fmul_sequencer_if.sv
// Bundle of the handshake and datapath signals of vec_fmul_sequencer.
//   master : the surrounding system (operand producer, result consumer and
//            the external combinational FP32 multiplier that drives mul_out)
//   slave  : the sequencer itself
// Signals:
//   start_valid / start_ready : operand pair handshake
//   vec_a, vec_b, lane_mask   : operand vectors (lane i = bits [32i+31:32i]) and lane enables
//   mul_a, mul_b, mul_out     : one-lane-per-cycle link to the external multiplier
//   res_valid / res_ready     : result handshake, res_vec carries the result vector
//   busy, lane_idx            : status (busy while multiplying, lane being processed)
interface vec_fmul_sequencer_if #(
  parameter int LANES = 4,
  parameter int IDXW  = 2
);
  logic                  start_valid;
  logic                  start_ready;
  logic [LANES*32-1:0]   vec_a;
  logic [LANES*32-1:0]   vec_b;
  logic [LANES-1:0]      lane_mask;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_out;
  logic                  res_valid;
  logic                  res_ready;
  logic [LANES*32-1:0]   res_vec;
  logic                  busy;
  logic [IDXW-1:0]       lane_idx;

  modport master (
    output start_valid, vec_a, vec_b, lane_mask, mul_out, res_ready,
    input  start_ready, mul_a, mul_b, res_valid, res_vec, busy, lane_idx
  );

  modport slave (
    input  start_valid, vec_a, vec_b, lane_mask, mul_out, res_ready,
    output start_ready, mul_a, mul_b, res_valid, res_vec, busy, lane_idx
  );
endinterface

// File: rtl/vec_fmul_sequencer.sv
// Sequences an element-wise FP32 vector multiply through a single external
// combinational multiplier, one lane per clock.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : vec_fmul_sequencer_if slave modport (operand handshake, multiplier
//         link, result handshake, busy / lane_idx status)
// Flow: IDLE accepts an operand pair, RUN spends exactly LANES cycles feeding
// lane lane_idx to the multiplier and storing its product (or zero for a
// masked-off lane), DONE presents the result until the consumer takes it.
module vec_fmul_sequencer #(
  parameter int LANES = 4,
  parameter int IDXW  = 2
) (
  input logic                 clk,
  input logic                 rst,
  vec_fmul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state;
  logic [LANES*32-1:0]   op_a;
  logic [LANES*32-1:0]   op_b;
  logic [LANES-1:0]      mask;
  logic [LANES*32-1:0]   res;
  logic [IDXW-1:0]       lane_idx;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic                  start_ready;
  logic                  res_valid;
  logic                  busy;

  // All outputs are registered. mul_a/mul_b are loaded one cycle ahead with
  // the lane that the next RUN cycle will multiply, so they always match
  // lane_idx while in RUN and are zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      mask        <= '0;
      res         <= '0;
      lane_idx    <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            op_a        <= bus.vec_a;
            op_b        <= bus.vec_b;
            mask        <= bus.lane_mask;
            lane_idx    <= '0;
            mul_a       <= bus.vec_a[31:0];
            mul_b       <= bus.vec_b[31:0];
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end

        RUN: begin
          // Masked-off lanes are written with zero rather than left stale.
          res[int'(lane_idx)*32 +: 32] <= mask[lane_idx] ? bus.mul_out : 32'h0;
          if (lane_idx == IDXW'(LANES - 1)) begin
            mul_a     <= 32'h0;
            mul_b     <= 32'h0;
            busy      <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            lane_idx <= lane_idx + IDXW'(1);
            mul_a    <= op_a[(int'(lane_idx) + 1)*32 +: 32];
            mul_b    <= op_b[(int'(lane_idx) + 1)*32 +: 32];
          end
        end

        DONE: begin
          if (bus.res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          mul_a       <= 32'h0;
          mul_b       <= 32'h0;
          start_ready <= 1'b1;
          res_valid   <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.res_valid   = res_valid;
  assign bus.busy        = busy;
  assign bus.lane_idx    = lane_idx;
  assign bus.mul_a       = mul_a;
  assign bus.mul_b       = mul_b;
  assign bus.res_vec     = res;

endmodule

// File: doc/vec_fmul_sequencer.md
VEC_FMUL_SEQUENCER -- requirements
Module: vec_fmul_sequencer

Interface
REQ-001 The block SHALL have parameter LANES, default 4: number of 32-bit elements per vector operand (2..16).
REQ-002 The block SHALL have parameter IDXW, default 2: lane index width, equal to ceil(log2(LANES)).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_valid, input, 1 bit: an operand pair is offered.
REQ-006 The block SHALL have port start_ready, output, 1 bit: the block can accept an operand pair.
REQ-007 The block SHALL have port vec_a, input, LANES*32 bits: operand A vector; lane i is bits [32i+31:32i].
REQ-008 The block SHALL have port vec_b, input, LANES*32 bits: operand B vector, same packing as vec_a.
REQ-009 The block SHALL have port lane_mask, input, LANES bits: bit i = 1 enables lane i.
REQ-010 The block SHALL have port mul_a, output, 32 bits: operand A to the external combinational FP32 multiplier.
REQ-011 The block SHALL have port mul_b, output, 32 bits: operand B to the external multiplier.
REQ-012 The block SHALL have port mul_out, input, 32 bits: product returned by the external multiplier in the same cycle.
REQ-013 The block SHALL have port res_valid, output, 1 bit: res_vec holds a completed result.
REQ-014 The block SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-015 The block SHALL have port res_vec, output, LANES*32 bits: result vector, same packing as vec_a.
REQ-016 The block SHALL have port busy, output, 1 bit: high while the FSM is in state RUN.
REQ-017 The block SHALL have port lane_idx, output, IDXW bits: the lane currently being multiplied.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 In IDLE: start_ready = 1, and a cycle with start_valid = 1 SHALL capture vec_a, vec_b and lane_mask into internal registers, clear lane_idx to 0 and move to RUN.
REQ-020 In RUN: mul_a and mul_b SHALL be lane lane_idx of the captured A and B; mul_a and mul_b SHALL be 32'h0 in every other state.
REQ-021 In RUN, each cycle SHALL write lane lane_idx of the result register with mul_out when the captured mask bit is 1, or with 32'h0 when it is 0.
REQ-022 In RUN, lane_idx SHALL increment by 1 per cycle; the cycle with lane_idx = LANES-1 SHALL move to DONE, with no wrap-around into a new pass.
REQ-023 Latency: for a handshake in cycle T, RUN SHALL occupy cycles T+1..T+LANES, and res_valid SHALL be first high in cycle T+LANES+1.
REQ-024 In DONE: res_valid = 1, res_vec stable, start_ready = 0; a cycle with res_ready = 1 SHALL move to IDLE.
REQ-025 res_valid and start_ready SHALL never be high in the same cycle; start_valid SHALL be ignored outside IDLE.
REQ-026 Changes on vec_a, vec_b or lane_mask after the handshake SHALL NOT affect the result in progress.
REQ-027 res_vec SHALL keep its last result after leaving DONE until the next write in RUN.
REQ-028 Arithmetic is delegated entirely to the external multiplier; the block SHALL NOT modify mul_out bits.
REQ-029 lane_mask = all zeros SHALL still take LANES RUN cycles and produce an all-zero res_vec.

Reset
REQ-030 While rst = 1 at a clock edge: state = IDLE, lane_idx = 0, and the result, operand and mask registers = 0.
REQ-031 After reset the outputs SHALL be: start_ready = 1, res_valid = 0, busy = 0, mul_a = mul_b = 0, res_vec = 0.
REQ-032 rst asserted in RUN or DONE SHALL abort the operation with no result presented; the next cycle behaves as IDLE.

Verification (bench instantiates the team's combinational FP32 multiplier on mul_a/mul_b/mul_out)
REQ-033 A bench test SHALL check: LANES=4, A = {0x3F800000, 0xBFC00000, 0x40400000, 0x00000000}, B = {0x40000000, 0x40000000, 0x3F000000, 0x40000000}, mask 4'hF -> res_vec = {0x40000000, 0xC0400000, 0x3FC00000, 0x00000000}, with res_valid at T+5.
REQ-034 A bench test SHALL check: same operands with mask 4'b0101 -> lanes 1 and 3 = 0x00000000, lanes 0 and 2 as in REQ-033.
REQ-035 A bench test SHALL check: res_ready held 0 for 10 cycles in DONE -> res_valid stays 1, res_vec stable, start_ready = 0, and start_valid pulses ignored.
REQ-036 A bench test SHALL check: back-to-back operations where res_ready = 1 on DONE entry and start_valid = 1 continuously -> successive res_valid pulses spaced exactly LANES+2 cycles apart.
REQ-037 A bench test SHALL check: rst pulsed in the RUN cycle with lane_idx = 2 -> the next cycle shows start_ready = 1, busy = 0, res_vec = 0, and no res_valid pulse.
REQ-038 A bench test SHALL check: vec_a changed to 0xFFFFFFFF in all lanes during RUN -> result matches the captured operands.
